// File: rtl/ram_sync.sv
// Single-port synchronous RAM with registered read data, a valid strobe,
// selectable read-during-write behaviour and a post-reset zero-fill sweep.
module ram_sync #(
    parameter int DATA_W         = 4,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 4096,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ren_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              in_range;
    logic              clearing;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign in_range = ({1'b0, addr_i} < DEPTH_X);
    assign clearing = (CLEAR_ON_RESET != 0) && (state == CLEAR);
    assign busy_o   = clearing;

    // The sweep and normal writes share the one write port so the array maps to block RAM.
    always_comb begin
        we    = 1'b0;
        waddr = addr_i;
        wdata = din_i;
        if (!rst_i) begin
            if (clearing) begin
                we    = 1'b1;
                waddr = ptr;
                wdata = '0;
            end else if (wen_i && in_range) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr     <= '0;
            dout_o  <= '0;
            valid_o <= 1'b0;
        end else if (clearing) begin
            dout_o  <= '0;
            valid_o <= 1'b0;
            ptr     <= ptr + 1'b1;
            if (ptr == LAST) begin
                state <= IDLE;
            end
        end else begin
            valid_o <= ren_i;
            if (ren_i && in_range) begin
                // Non-blocking read of mem yields the pre-write word (read-first).
                if ((RDW_MODE != 0) && wen_i) begin
                    dout_o <= din_i;
                end else begin
                    dout_o <= mem[addr_i[IDX_W-1:0]];
                end
            end else begin
                dout_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Directed and randomised checks of ram_sync in read-first, write-first and
// no-clear/short-depth configurations, all driven by one shared stimulus.
module tb_ram_sync;

    localparam int DW = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout [3];
    logic          valid [3];
    logic          busy [3];

    always #5 clk = ~clk;

    ram_sync #(.RDW_MODE(0)) u_rf (
        .clk_i(clk), .rst_i(rst), .ren_i(ren), .wen_i(wen), .addr_i(addr), .din_i(din),
        .dout_o(dout[0]), .valid_o(valid[0]), .busy_o(busy[0])
    );

    ram_sync #(.RDW_MODE(1)) u_wf (
        .clk_i(clk), .rst_i(rst), .ren_i(ren), .wen_i(wen), .addr_i(addr), .din_i(din),
        .dout_o(dout[1]), .valid_o(valid[1]), .busy_o(busy[1])
    );

    ram_sync #(.DEPTH(3000), .CLEAR_ON_RESET(0), .RDW_MODE(0)) u_nc (
        .clk_i(clk), .rst_i(rst), .ren_i(ren), .wen_i(wen), .addr_i(addr), .din_i(din),
        .dout_o(dout[2]), .valid_o(valid[2]), .busy_o(busy[2])
    );

    int  depth [3] = '{4096, 4096, 3000};
    bit  rdw   [3] = '{1'b0, 1'b1, 1'b0};
    bit  cor   [3] = '{1'b1, 1'b1, 1'b0};

    logic [DW-1:0] mm  [3][4096];
    bit            kn  [3][4096];
    logic [DW-1:0] exp_d  [3];
    bit            exp_dk [3];
    bit            exp_v  [3];
    int            cnt    [3];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_d[i]  = '0;
                exp_dk[i] = 1'b1;
                exp_v[i]  = 1'b0;
                cnt[i]    = cor[i] ? depth[i] : 0;
            end else if (cnt[i] > 0) begin
                mm[i][depth[i] - cnt[i]] = '0;
                kn[i][depth[i] - cnt[i]] = 1'b1;
                cnt[i]--;
                exp_d[i]  = '0;
                exp_dk[i] = 1'b1;
                exp_v[i]  = 1'b0;
            end else begin
                exp_v[i]  = ren;
                exp_d[i]  = '0;
                exp_dk[i] = 1'b1;
                if (ren && int'(addr) < depth[i]) begin
                    if (wen && rdw[i]) begin
                        exp_d[i] = din;
                    end else begin
                        exp_d[i]  = mm[i][addr];
                        exp_dk[i] = kn[i][addr];
                    end
                end
                if (wen && int'(addr) < depth[i]) begin
                    mm[i][addr] = din;
                    kn[i][addr] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("busy[%0d]", i), busy[i], cnt[i] > 0);
            check_eq($sformatf("valid[%0d]", i), valid[i], exp_v[i]);
            if (exp_dk[i]) check_eq($sformatf("dout[%0d]", i), dout[i], exp_d[i]);
        end
    endtask

    // Counts cycles busy is seen high, starting from the sample right after the reset edge.
    task automatic sweep_len(output int n);
        n = busy[0] ? 1 : 0;
        for (int c = 0; c < 5000 && busy[0]; c++) begin
            cyc();
            if (busy[0]) n++;
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return AW'($urandom_range(0, 15));
            1:       return AW'($urandom_range(2990, 3005));
            default: return AW'($urandom_range(4088, 4095));
        endcase
    endfunction

    int n;

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
        cyc();
        check_eq("rst_busy_rf", busy[0], 1);
        check_eq("rst_busy_nc", busy[2], 0);

        // 1: sweep length with a read held at the top address
        rst = 1'b0; ren = 1'b1; addr = 12'hFFF;
        sweep_len(n);
        check_eq("t1_busy_len", n, 4096);
        check_eq("t1_busy_end", busy[0], 0);
        cyc();
        check_eq("t1_top_dout", dout[0], 0);
        check_eq("t1_top_valid", valid[0], 1);
        addr = '0;
        cyc();
        check_eq("t1_zero_dout", dout[0], 0);
        check_eq("t1_zero_valid", valid[0], 1);

        // 2: write then read, output returns to zero when idle
        ren = 1'b0; wen = 1'b1; addr = 12'h123; din = 4'hA;
        cyc();
        wen = 1'b0; ren = 1'b1;
        cyc();
        check_eq("t2_dout", dout[0], 4'hA);
        check_eq("t2_valid", valid[0], 1);
        ren = 1'b0;
        cyc();
        check_eq("t2_idle_dout", dout[0], 0);
        check_eq("t2_idle_valid", valid[0], 0);

        // 3: read-during-write
        wen = 1'b1; addr = 12'h010; din = 4'h5;
        cyc();
        ren = 1'b1; din = 4'hC;
        cyc();
        check_eq("t3_rdw_old", dout[0], 4'h5);
        check_eq("t3_rdw_new", dout[1], 4'hC);
        wen = 1'b0;
        cyc();
        check_eq("t3_after_rf", dout[0], 4'hC);
        check_eq("t3_after_wf", dout[1], 4'hC);

        // 5: short depth, no clear: out-of-range write dropped, last word usable
        ren = 1'b0; wen = 1'b1; addr = 12'd3000; din = 4'h9;
        cyc();
        wen = 1'b0; ren = 1'b1;
        cyc();
        check_eq("t5_oor_dout", dout[2], 0);
        check_eq("t5_oor_valid", valid[2], 1);
        ren = 1'b0; wen = 1'b1; addr = 12'd2999;
        cyc();
        wen = 1'b0; ren = 1'b1;
        cyc();
        check_eq("t5_last_dout", dout[2], 4'h9);
        check_eq("t5_busy_nc", busy[2], 0);

        // 4: reset mid-read and mid-sweep
        ren = 1'b0; wen = 1'b1; addr = 12'h7FF; din = 4'hF;
        cyc();
        wen = 1'b0; ren = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("t4_rst_valid_nc", valid[2], 0);
        check_eq("t4_rst_dout_nc", dout[2], 0);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) cyc();
        rst = 1'b1;
        cyc();
        check_eq("t4_midclear_busy", busy[0], 1);
        rst = 1'b0;
        sweep_len(n);
        check_eq("t4_busy_len", n, 4096);
        addr = 12'h7FF; ren = 1'b1;
        cyc();
        check_eq("t4_cleared_dout", dout[0], 0);
        check_eq("t4_cleared_valid", valid[0], 1);
        check_eq("t4_kept_nc", dout[2], 4'hF);

        // 6: random traffic against the models
        for (int c = 0; c < 10000; c++) begin
            ren  = 1'($urandom_range(0, 1));
            wen  = 1'($urandom_range(0, 1));
            addr = pick_addr();
            din  = DW'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
